// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   SZ_*    : store-size codes driven on mem_store_signal
//   state_e : lock FSM states
//   req_t   : one requester's access payload
//   rsp_t   : registered response payload
package dmem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned NPORTS = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SZ_NOP  = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic              write;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SIZE_W-1:0] size;
    } req_t;

    typedef struct packed {
        logic [NPORTS-1:0] valid;
        logic [NPORTS-1:0] err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    // Word address falls inside a memory of 'depth' words.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned      depth);
        return addr < ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker with a lock override.
//   clk, rst_n : clock, async active-low reset
//   valid_i    : per-port request valid
//   force_i    : grant owner_i unconditionally (caller asserts only when owner is valid)
//   owner_i    : port to grant while force_i is high
//   grant_c_o  : one-hot grant, combinational
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       force_i,
    input  logic       owner_i,
    output logic [1:0] grant_c_o
);

    logic last_q;
    logic last_d;

    // Grant selection: lock owner, else alternate on contention, else the lone requester.
    always_comb begin
        grant_c_o = 2'b00;
        if (force_i) begin
            grant_c_o = owner_i ? 2'b10 : 2'b01;
        end else if (valid_i == 2'b11) begin
            grant_c_o = last_q ? 2'b01 : 2'b10;
        end else begin
            grant_c_o = valid_i;
        end
    end

    // Remember the most recently granted port.
    always_comb begin
        last_d = last_q;
        if (grant_c_o != 2'b00) begin
            last_d = grant_c_o[1];
        end
    end

    // Reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core load/store port (0)
// and the debug/program-load port (1), with a bounded lock for atomic sequences.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/ready     : per-port handshake (ready is the combinational grant)
//   req_write/lock      : per-port store flag and hold-grant request
//   req_addr*/wdata*/size* : per-port access payload
//   rsp_valid/err/rdata : registered response, one cycle after the grant
//   mem_*               : combinational drive of the memory from the granted port
//   mem_data            : combinational read data from the memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    input  logic [SIZE_W-1:0] req_size0,
    input  logic [SIZE_W-1:0] req_size1,
    output logic [1:0]        rsp_valid,
    output logic [1:0]        rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [SIZE_W-1:0] mem_store_signal,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    state_e           state_q;
    state_e           state_d;
    logic             owner_q;
    logic             owner_d;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;
    rsp_t             rsp_q;
    rsp_t             rsp_d;

    logic [1:0] valid_g;
    logic [1:0] grant;
    logic       gnt_any;
    logic       gnt_port;
    logic       lock_hold;
    logic       in_range;
    req_t       req0;
    req_t       req1;
    req_t       sel;

    // Grants are suppressed while reset is asserted so nothing reaches the memory.
    assign valid_g   = req_valid & {2{rst_n}};

    // The lock is honoured only while its owner keeps requesting.
    assign lock_hold = (state_q == LOCKED) && valid_g[owner_q];

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_g),
        .force_i   (lock_hold),
        .owner_i   (owner_q),
        .grant_c_o (grant)
    );

    assign req_ready = grant;
    assign gnt_any   = |grant;
    assign gnt_port  = grant[1];

    assign req0 = '{write: req_write[0], lock: req_lock[0], addr: req_addr0,
                    wdata: req_wdata0, size: req_size0};
    assign req1 = '{write: req_write[1], lock: req_lock[1], addr: req_addr1,
                    wdata: req_wdata1, size: req_size1};
    assign sel  = gnt_port ? req1 : req0;

    assign in_range = addr_in_range(sel.addr, DEPTH);

    // Memory drive from the granted port; all zero when idle.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_store_signal = '0;
        mem_memWrite     = 1'b0;
        mem_memRead      = 1'b0;
        if (gnt_any) begin
            mem_address      = sel.addr;
            mem_write_data   = sel.wdata;
            mem_store_signal = sel.size;
            mem_memWrite     = sel.write & in_range;
            mem_memRead      = ~sel.write & in_range;
        end
    end

    // Response payload captured at the grant edge.
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = grant;
        rsp_d.err   = grant & {2{~in_range}};
        if (gnt_any && !sel.write && in_range) begin
            rsp_d.rdata = mem_data;
        end
    end

    // Lock FSM: outside a held lock, a granted access with lock set claims it;
    // inside, every owner grant counts and the lock ends on lock=0 or the cap.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (!lock_hold) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
            if (gnt_any && sel.lock && (32'(MAX_LOCK) > 32'd1)) begin
                state_d    = LOCKED;
                owner_d    = gnt_port;
                lock_cnt_d = CNT_W'(1);
            end
        end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
            if (!sel.lock || (32'(lock_cnt_q) + 32'd1 >= 32'(MAX_LOCK))) begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        end
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            lock_cnt_q <= '0;
            rsp_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rsp_q      <= rsp_d;
        end
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_err   = rsp_q.err;
    assign rsp_rdata = rsp_q.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned DEPTH    = 128;
    localparam int unsigned MAX_LOCK = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = 2'b00;
    logic [1:0]  req_lock  = 2'b00;
    logic [31:0] req_addr0 = '0, req_addr1 = '0;
    logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]  req_size0 = '0, req_size1 = '0;
    logic [1:0]  rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_data;
    logic [1:0]  mem_store_signal;
    logic        mem_memWrite, mem_memRead;

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_size0(req_size0), .req_size1(req_size1),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_store_signal(mem_store_signal),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return {old[31:8], wd[7:0]};
            SZ_HALF: return {old[31:16], wd[15:0]};
            SZ_WORD: return wd;
            default: return old;
        endcase
    endfunction

    // The data memory the arbiter drives.
    logic [31:0] devmem [DEPTH] = '{default: 32'h0};
    assign mem_data = (mem_address < 32'(DEPTH)) ? devmem[mem_address[6:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_memWrite && mem_address < 32'(DEPTH))
            devmem[mem_address[6:0]] <= merge(devmem[mem_address[6:0]], mem_write_data, mem_store_signal);
    end

    // Reference model state.
    logic [31:0] shadow [DEPTH] = '{default: 32'h0};
    int          m_last;
    bit          m_locked;
    int          m_owner;
    int          m_cnt;
    logic [1:0]  exp_rv, exp_err;
    logic [31:0] exp_rd;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  o_ready, o_rv, o_err;
    logic        o_rd;
    logic [31:0] o_rdata;

    logic [1:0]  pv, pw, pl;
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [1:0]  ps [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_locked = 0; m_owner = 0; m_cnt = 0;
        exp_rv = 2'b00; exp_err = 2'b00; exp_rd = 32'h0;
    endtask

    // One clock of traffic: drive, check combinational and registered outputs, advance model.
    task automatic cycle(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] s0, input logic [1:0] s1, output int g);
        bit          held;
        bit          inr;
        logic        ew;
        logic [31:0] ea, ed;
        logic [1:0]  es, er;
        req_valid = v; req_write = w; req_lock = l;
        req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
        req_size0 = s0; req_size1 = s1;
        @(negedge clk);
        held = m_locked && v[m_owner];
        if (v == 2'b00)       g = -1;
        else if (held)        g = m_owner;
        else if (v == 2'b11)  g = (m_last == 0) ? 1 : 0;
        else                  g = v[0] ? 0 : 1;
        ea = 0; ed = 0; es = 0; ew = 0; inr = 0; er = 2'b00;
        if (g >= 0) begin
            ea = (g == 1) ? a1 : a0;  ed = (g == 1) ? d1 : d0;
            es = (g == 1) ? s1 : s0;  ew = w[g];
            inr = (ea < 32'(DEPTH));
            er = 2'(1 << g);
        end
        o_ready = req_ready; o_rd = mem_memRead;
        o_rv = rsp_valid; o_err = rsp_err; o_rdata = rsp_rdata;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_err",   32'(rsp_err),   32'(exp_err));
        chk("rsp_rdata", rsp_rdata,      exp_rd);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("mem_memWrite", 32'(mem_memWrite), 32'(ew & inr));
        chk("mem_memRead",  32'(mem_memRead),  32'((g >= 0) && !ew && inr));
        chk("mem_address",  mem_address, ea);
        chk("mem_write_data", mem_write_data, ed);
        chk("mem_store_signal", 32'(mem_store_signal), 32'(es));
        @(posedge clk);
        exp_rv = er;
        exp_err = inr ? 2'b00 : er;
        exp_rd = (g >= 0 && !ew && inr) ? shadow[ea[6:0]] : 32'h0;
        if (g >= 0) begin
            if (ew && inr) shadow[ea[6:0]] = merge(shadow[ea[6:0]], ed, es);
            m_last = g;
        end
        if (!held) begin
            m_locked = 0; m_cnt = 0;
            if (g >= 0 && l[g]) begin m_locked = 1; m_owner = g; m_cnt = 1; end
        end else begin
            m_cnt++;
            if (!l[g] || m_cnt >= MAX_LOCK) begin m_locked = 0; m_cnt = 0; end
        end
        #1;
    endtask

    task automatic one(input int p, input logic wr, input logic lk, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s, output int g);
        cycle((p == 0) ? 2'b01 : 2'b10, {wr, wr}, {lk, lk}, a, a, d, d, s, s, g);
    endtask

    task automatic idle(output int g);
        cycle(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, g);
    endtask

    task automatic gen(input int k);
        pv[k] = ($urandom_range(0, 3) != 0);
        pw[k] = 1'($urandom_range(0, 1));
        pl[k] = ($urandom_range(0, 3) == 0);
        pa[k] = ($urandom_range(0, 15) == 0) ? 32'(DEPTH + $urandom_range(0, 20))
                                             : 32'($urandom_range(0, 15));
        pd[k] = $urandom;
        ps[k] = 2'($urandom_range(0, 3));
    endtask

    initial begin
        int g, run;
        int a [2];
        logic l1;

        // Bring up and preload a few words.
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            one(0, 1'b1, 1'b0, 32'(10 + i), 32'h1000_0000 + 32'(i), SZ_WORD, g);
            one(1, 1'b1, 1'b0, 32'(20 + i), 32'h2000_0000 + 32'(i), SZ_WORD, g);
        end

        // Reset with both ports requesting.
        rst_n = 1'b0; req_valid = 2'b11; req_write = 2'b00;
        model_reset();
        @(negedge clk);
        chk("rst_ready",     32'(req_ready), 0);
        chk("rst_memWrite",  32'(mem_memWrite), 0);
        chk("rst_memRead",   32'(mem_memRead), 0);
        chk("rst_address",   mem_address, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_state",     32'(dut.state_q), 32'(IDLE));
        chk("rst_lock_cnt",  32'(dut.lock_cnt_q), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: alternating grants starting with port 0.
        a[0] = 10; a[1] = 20;
        for (int i = 0; i < 6; i++) begin
            cycle(2'b11, 2'b00, 2'b00, 32'(a[0]), 32'(a[1]), 0, 0, SZ_WORD, SZ_WORD, g);
            chk("rr_order", 32'(o_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (g >= 0) a[g]++;
        end
        idle(g);

        // Store sizes merge into the low lanes; size 11 writes nothing.
        one(0, 1'b1, 1'b0, 5, 32'hAABBCCDD, SZ_WORD, g);
        one(0, 1'b1, 1'b0, 5, 32'h00000011, SZ_BYTE, g);
        one(0, 1'b1, 1'b0, 5, 32'h00002233, SZ_HALF, g);
        one(0, 1'b0, 1'b0, 5, 0, SZ_WORD, g);
        idle(g);
        chk("size_merge", o_rdata, 32'hAABB2233);
        one(0, 1'b1, 1'b0, 5, 32'hFFFFFFFF, SZ_NOP, g);
        one(0, 1'b0, 1'b0, 5, 0, SZ_WORD, g);
        idle(g);
        chk("size_nop", o_rdata, 32'hAABB2233);

        // Address range boundary.
        one(1, 1'b0, 1'b0, 128, 0, SZ_WORD, g);
        chk("oor_memRead", 32'(o_rd), 0);
        idle(g);
        chk("oor_err",   32'(o_err), 32'h2);
        chk("oor_rdata", o_rdata, 0);
        one(1, 1'b0, 1'b0, 127, 0, SZ_WORD, g);
        chk("inr_memRead", 32'(o_rd), 1);
        idle(g);
        chk("inr_err",   32'(o_err), 0);
        chk("inr_valid", 32'(o_rv), 32'h2);

        // Lock held to the cap against a waiting port 0.
        one(0, 1'b0, 1'b0, 1, 0, SZ_WORD, g);
        run = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(2'b11, 2'b00, 2'b10, 3, 32'(40 + i), 0, 0, SZ_WORD, SZ_WORD, g);
            if (o_ready == 2'b10) run++;
            else break;
        end
        chk("lock_max_run",  32'(run), 32'(MAX_LOCK));
        chk("lock_max_next", 32'(o_ready), 32'h1);
        idle(g);

        // Lock released by clearing req_lock on the third access.
        one(0, 1'b0, 1'b0, 1, 0, SZ_WORD, g);
        run = 0;
        for (int i = 0; i < 10; i++) begin
            l1 = (run < 2);
            cycle(2'b11, 2'b00, {l1, 1'b0}, 3, 32'(50 + i), 0, 0, SZ_WORD, SZ_WORD, g);
            if (o_ready == 2'b10) run++;
            else break;
        end
        chk("lock_clr_run",  32'(run), 3);
        chk("lock_clr_next", 32'(o_ready), 32'h1);
        idle(g);

        // Reset right after a locking load grant drops the response.
        one(0, 1'b1, 1'b0, 9, 32'hCAFEF00D, SZ_WORD, g);
        one(0, 1'b0, 1'b1, 9, 0, SZ_WORD, g);
        rst_n = 1'b0; req_valid = 2'b00;
        model_reset();
        @(negedge clk);
        chk("rst_mid_rsp",   32'(rsp_valid), 0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_mid_cnt",   32'(dut.lock_cnt_q), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        one(0, 1'b0, 1'b0, 9, 0, SZ_WORD, g);
        idle(g);
        chk("rst_mem_keep", o_rdata, 32'hCAFEF00D);

        // Randomized traffic; a waiting request stays stable until granted.
        gen(0); gen(1);
        for (int c = 0; c < 400; c++) begin
            cycle(pv, pw, pl, pa[0], pa[1], pd[0], pd[1], ps[0], ps[1], g);
            for (int k = 0; k < 2; k++)
                if (!pv[k] || g == k) gen(k);
        end
        idle(g);
        idle(g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-port data memory. It shares the memory between requester 0 (the core load/store stage) and requester 1 (the debug/program-load port), and drives the memory's address, write-data, write/read strobes and 2-bit store-size code. It returns registered read data with a per-port response strobe. It also supports a bounded lock so one requester can do back-to-back accesses atomically, for example a read-modify-write.

## Interface
- DEPTH, 128: memory depth in words; valid addresses are 0..DEPTH-1.
- MAX_LOCK, 8: maximum consecutive grants to a locking requester.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to requester i.
- req_ready  out  2  per-port accept; a transfer happens when valid & ready are both high.
- req_write  in  2  1 = store, 0 = load.
- req_lock  in  2  hold the grant on this port after the current access.
- req_addr0, req_addr1  in  32  word address.
- req_wdata0, req_wdata1  in  32  store data.
- req_size0, req_size1  in  2  store size: 00 = byte, 01 = half, 10 = word, 11 = no-op.
- rsp_valid  out  2  one-cycle response strobe per port.
- rsp_err  out  2  qualified by rsp_valid; 1 means the address was out of range.
- rsp_rdata  out  32  load data, qualified by rsp_valid (shared bus; only one bit of rsp_valid is ever high).
- mem_address  out  32  to the data memory.
- mem_write_data  out  32  to the data memory.
- mem_store_signal  out  2  to the data memory.
- mem_memWrite  out  1  to the data memory.
- mem_memRead  out  1  to the data memory.
- mem_data  in  32  combinational read data from the data memory.

## Operation
- At most one grant per cycle.
- Grant choice:
  - If the FSM is LOCKED, the grant goes to the lock owner.
  - Otherwise, if both ports are valid, the grant goes to the port not granted most recently (round-robin).
  - Otherwise, the grant goes to the single valid port.
- req_ready is combinational: ready[i] = grant[i]. The ungranted port stalls and keeps its request stable.
- Memory outputs are driven combinationally from the granted port in the grant cycle:
  - mem_memWrite = write & in-range.
  - mem_memRead = ~write & in-range.
  - address, data and size are passed through.
- With no grant, all mem strobes are 0 and mem_address/mem_write_data/mem_store_signal are 0.
- Out-of-range access (addr ≥ DEPTH): no memory strobe is raised; the response is returned with rsp_err = 1 and rsp_rdata = 0.
- Size 11 is accepted and responded to normally; the memory performs no write.
- The response register captures grant port, error flag and mem_data (loads) or 0 (stores) at the grant edge.
- FSM states: IDLE, LOCKED.
  - IDLE → LOCKED: a granted access has req_lock = 1. The owner is latched and lock_cnt is set to 1.
  - In LOCKED, each further owner grant increments lock_cnt.
  - LOCKED → IDLE: the owner makes an access with req_lock = 0, or lock_cnt reaches MAX_LOCK, or the owner drops req_valid (no idle cycles are allowed under lock).
  - On forced release by MAX_LOCK, round-robin resumes and the other port wins the next contention.
- Round-robin pointer last_grant is updated on every grant.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - All mem_* outputs = 0.
  - FSM = IDLE, lock_cnt = 0.
  - last_grant = 1, so port 0 wins the first contention.
- Store: the memory writes at the edge that ends grant cycle N. rsp_valid pulses in cycle N+1.
- Load: mem_data is sampled at the end of cycle N. rsp_rdata/rsp_valid are valid in cycle N+1. Throughput is one access per cycle.
- Load after store to the same address, on consecutive grants: the load sees the new data.
- There is no response back-pressure; the requester must take rsp_valid when it arrives.
- Reset asserted mid-operation: state clears immediately; any in-flight response is dropped (no rsp_valid); the memory contents are untouched.

## Structure
- Shared package dmem_pkg holds:
  - store-size localparams SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_NOP = 2'b11.
  - FSM state typedef {IDLE, LOCKED}.
- One natural sub-module: rr_arb2, a two-input round-robin picker with a last-grant register and a force/owner input for lock.

## Test plan
- Reset: hold rst_n = 0, both ports valid → req_ready = 00, all mem strobes 0. Release → port 0 granted first.
- Contention: both ports issue word loads every cycle → grants alternate 0,1,0,1. Each rsp_valid arrives one cycle after its grant with the correct data.
- Sizes: port 0 stores 0xAABBCCDD word to addr 5, then byte 0x11, then half 0x2233 → a load returns 0xAABB2233. A size-11 store leaves the value unchanged.
- Range: port 1 loads addr 128 → no mem_memRead, rsp_err = 1, rsp_rdata = 0. Addr 127 → rsp_err = 0.
- Lock: port 1 locks with port 0 valid throughout → port 1 gets exactly MAX_LOCK = 8 consecutive grants, then port 0 is granted.
- Lock: port 1 locks for 3 accesses then clears req_lock → port 1 gets 3 grants, then port 0 is granted.
- Mid-operation reset: assert rst_n low in the cycle after a load grant → no rsp_valid, FSM = IDLE, and the memory word written before the reset persists.
